// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, framing sizes
// and small state-classification helpers.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_WRITE,
        ST_RD,
        ST_CMP,
        ST_DONE,
        ST_ERR
    } state_t;

    // States in which a new session may be started.
    function automatic logic st_is_rest(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

    // States in which the byte stream is consumed.
    function automatic logic st_accepts(input state_t s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: the first accepted byte lands in bits [7:0].
// o_full flags the cycle in which the last byte of a word is being accepted.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_count,
    output logic [31:0] o_word,
    output logic        o_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
        end else if (i_valid) begin
            r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
            r_cnt                        <= r_cnt + 2'd1;
        end
    end

    assign o_count = r_cnt;
    assign o_word  = r_word;
    assign o_full  = i_valid && (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then enables the CPU.
// Optional write-readback verification is enabled by defining IMEM_LOADER_READBACK_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 512
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error
);

    localparam int              HDR_W = 8 * HDR_BYTES;
    localparam logic [HDR_W-1:0] MAX_N = HDR_W'(MAX_WORDS);

    state_t           r_state;
    state_t           w_nxt;
    logic [7:0]       r_n_lo;
    logic [HDR_W-1:0] r_n;
    logic [HDR_W-1:0] r_idx;
    logic [HDR_W-1:0] w_idx_inc;
    logic [HDR_W-1:0] w_hdr;
    logic             r_s_ready;
    logic             r_wen;
    logic             r_cpu_en;
    logic             r_busy;
    logic             r_error;
    logic             w_xfer;
    logic             w_start;
    logic             w_last;
    logic             w_adv;
    logic             w_pk_full;
    logic [1:0]       w_pk_cnt;
    logic [31:0]      w_pk_word;
    logic             w_unused;

    assign w_xfer    = s_valid & r_s_ready;
    assign w_start   = start & st_is_rest(r_state);
    assign w_hdr     = {s_data, r_n_lo};
    assign w_idx_inc = r_idx + HDR_W'(1);
    assign w_last    = (w_idx_inc == r_n);

    byte_packer u_packer (
        .i_clk   (clk),
        .i_arst  (arst),
        .i_clr   (w_start),
        .i_valid (w_xfer && (r_state == ST_DATA)),
        .i_byte  (s_data),
        .o_count (w_pk_cnt),
        .o_word  (w_pk_word),
        .o_full  (w_pk_full)
    );

`ifdef IMEM_LOADER_READBACK_EN
    logic r_ren;
    // Index only advances once the readback of the current word has matched.
    assign w_adv    = (r_state == ST_CMP) && (rdata_ext == w_pk_word);
    assign ren_ext  = r_ren;
    assign w_unused = ^w_pk_cnt;
`else
    assign w_adv    = (r_state == ST_WRITE);
    assign ren_ext  = 1'b0;
    assign w_unused = ^{w_pk_cnt, rdata_ext};
`endif

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_nxt = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (w_xfer) w_nxt = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (w_xfer) begin
                    if (w_hdr == '0)        w_nxt = ST_DONE;
                    else if (w_hdr > MAX_N) w_nxt = ST_ERR;
                    else                    w_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_pk_full) w_nxt = ST_WRITE;
            end
`ifdef IMEM_LOADER_READBACK_EN
            ST_WRITE: w_nxt = ST_RD;
            ST_RD:    w_nxt = ST_CMP;
            ST_CMP: begin
                if (rdata_ext != w_pk_word) w_nxt = ST_ERR;
                else                        w_nxt = w_last ? ST_DONE : ST_DATA;
            end
`else
            ST_WRITE: w_nxt = w_last ? ST_DONE : ST_DATA;
`endif
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_wen     <= 1'b0;
            r_cpu_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
            r_n_lo    <= '0;
            r_n       <= '0;
            r_idx     <= '0;
`ifdef IMEM_LOADER_READBACK_EN
            r_ren     <= 1'b0;
`endif
        end else begin
            r_state   <= w_nxt;
            r_s_ready <= st_accepts(w_nxt);
            r_wen     <= (w_nxt == ST_WRITE);
            r_cpu_en  <= (w_nxt == ST_DONE);
            r_busy    <= !st_is_rest(w_nxt);
            r_error   <= (w_nxt == ST_ERR);
`ifdef IMEM_LOADER_READBACK_EN
            r_ren     <= (w_nxt == ST_RD);
`endif
            if ((r_state == ST_HDR_LO) && w_xfer) r_n_lo <= s_data;
            if ((r_state == ST_HDR_HI) && w_xfer) r_n    <= w_hdr;
            if (w_start)    r_idx <= '0;
            else if (w_adv) r_idx <= w_idx_inc;
        end
    end

    assign s_ready    = r_s_ready;
    assign wen_ext    = r_wen;
    assign cpu_enable = r_cpu_en;
    assign busy       = r_busy;
    assign error      = r_error;
    assign wdata_ext  = w_pk_word;
    assign addr_ext   = {{(64 - HDR_W - 2){1'b0}}, r_idx, 2'b00};

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: memory model, write log and checks of each session.
module tb_imem_loader;

    localparam int MAXW = 512;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext = 32'h0;
    logic        cpu_enable;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .arst       (arst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .rdata_ext  (rdata_ext),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [0:MAXW-1];
    logic [63:0] lg_addr [$];
    logic [31:0] lg_data [$];
    int          lg_cyc  [$];
    int          cyc        = 0;
    int          ren_cnt    = 0;
    int          both_cnt   = 0;
    int          rdy_wr_cnt = 0;
    logic        force_bad  = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wen_ext) begin
            mem[addr_ext[10:2]] <= wdata_ext;
            lg_addr.push_back(addr_ext);
            lg_data.push_back(wdata_ext);
            lg_cyc.push_back(cyc);
        end
        if (ren_ext) begin
            ren_cnt   <= ren_cnt + 1;
            rdata_ext <= force_bad ? 32'hDEADBEEF : mem[addr_ext[10:2]];
        end
        if (wen_ext && ren_ext) both_cnt <= both_cnt + 1;
        if (wen_ext && s_ready) rdy_wr_cnt <= rdy_wr_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_eq("rdy_tmo", {63'b0, s_ready}, 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n, input int gapmax);
        send_byte(n[7:0],  (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
        send_byte(n[15:8], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
    endtask

    task automatic begin_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("end_tmo", {63'b0, busy}, 64'd0);
    endtask

    function automatic logic [31:0] img_word(input int i);
        return {8'(i * 7 + 1), 8'hA5 ^ 8'(i), 8'(i), 8'h5A};
    endfunction

    logic [7:0] t1_bytes [8] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    int base;
    int rbase;

    initial begin
        arst    = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_s_ready", {63'b0, s_ready},    64'd0);
        check_eq("rst_wen",     {63'b0, wen_ext},    64'd0);
        check_eq("rst_ren",     {63'b0, ren_ext},    64'd0);
        check_eq("rst_cpu_en",  {63'b0, cpu_enable}, 64'd0);
        check_eq("rst_busy",    {63'b0, busy},       64'd0);
        check_eq("rst_error",   {63'b0, error},      64'd0);
        check_eq("rst_addr",    addr_ext,            64'd0);
        check_eq("rst_wdata",   {32'b0, wdata_ext},  64'd0);
        arst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", {63'b0, busy}, 64'd0);

        // Two-word image, continuous stream
        base = lg_addr.size();
        begin_session();
        check_eq("hdr_busy",  {63'b0, busy},    64'd1);
        check_eq("hdr_ready", {63'b0, s_ready}, 64'd1);
        send_hdr(16'h0002, 0);
        for (int i = 0; i < 8; i++) send_byte(t1_bytes[i], 0);
        wait_end();
        check_eq("t1_nwr",    64'(lg_addr.size() - base), 64'd2);
        if (lg_addr.size() >= base + 2) begin
            check_eq("t1_addr0", lg_addr[base],             64'd0);
            check_eq("t1_data0", {32'b0, lg_data[base]},    64'h00A00513);
            check_eq("t1_addr1", lg_addr[base+1],           64'd4);
            check_eq("t1_data1", {32'b0, lg_data[base+1]},  64'h00100593);
`ifdef IMEM_LOADER_READBACK_EN
            check_eq("t1_pace", 64'(lg_cyc[base+1] - lg_cyc[base]), 64'd7);
`else
            check_eq("t1_pace", 64'(lg_cyc[base+1] - lg_cyc[base]), 64'd5);
`endif
        end
        check_eq("t1_cpu_en", {63'b0, cpu_enable}, 64'd1);
        check_eq("t1_error",  {63'b0, error},      64'd0);

        // Zero-length image
        base = lg_addr.size();
        begin_session();
        check_eq("t2_cpu_clr", {63'b0, cpu_enable}, 64'd0);
        send_hdr(16'h0000, 0);
        wait_end();
        check_eq("t2_cpu_en", {63'b0, cpu_enable},        64'd1);
        check_eq("t2_nwr",    64'(lg_addr.size() - base), 64'd0);

        // Oversized image: 513 words
        base = lg_addr.size();
        begin_session();
        send_hdr(16'h0201, 0);
        wait_end();
        check_eq("t3_error",  {63'b0, error},             64'd1);
        check_eq("t3_cpu_en", {63'b0, cpu_enable},        64'd0);
        check_eq("t3_nwr",    64'(lg_addr.size() - base), 64'd0);

        // Start clears error; start while busy is ignored
        base = lg_addr.size();
        begin_session();
        check_eq("t4_err_clr", {63'b0, error}, 64'd0);
        check_eq("t4_busy",    {63'b0, busy},  64'd1);
        send_hdr(16'h0001, 0);
        send_byte(8'h0D, 0);
        send_byte(8'hF0, 0);
        begin_session();
        send_byte(8'hFE, 0);
        send_byte(8'hCA, 0);
        wait_end();
        check_eq("t4_nwr", 64'(lg_addr.size() - base), 64'd1);
        if (lg_addr.size() >= base + 1) begin
            check_eq("t4_addr", lg_addr[base],          64'd0);
            check_eq("t4_data", {32'b0, lg_data[base]}, 64'hCAFEF00D);
        end
        check_eq("t4_cpu_en", {63'b0, cpu_enable}, 64'd1);

        // 16-word image without and with s_valid gaps
        for (int pass = 0; pass < 2; pass++) begin
            base = lg_addr.size();
            begin_session();
            send_hdr(16'd16, pass * 3);
            for (int i = 0; i < 16; i++) send_word(img_word(i), pass * 3);
            wait_end();
            check_eq($sformatf("t5_nwr_p%0d", pass), 64'(lg_addr.size() - base), 64'd16);
            for (int i = 0; i < 16; i++)
                check_eq($sformatf("t5_mem_p%0d_w%0d", pass, i), {32'b0, mem[i]}, {32'b0, img_word(i)});
        end

        // Reset mid-word, then a fresh single-word session
        begin_session();
        send_hdr(16'h0001, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        arst = 1'b1;
        #1;
        check_eq("t6_rst_busy",  {63'b0, busy},      64'd0);
        check_eq("t6_rst_ready", {63'b0, s_ready},   64'd0);
        check_eq("t6_rst_wdata", {32'b0, wdata_ext}, 64'd0);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        base = lg_addr.size();
        begin_session();
        send_hdr(16'h0001, 0);
        send_word(32'h11223344, 0);
        wait_end();
        check_eq("t6_nwr",    64'(lg_addr.size() - base), 64'd1);
        check_eq("t6_mem0",   {32'b0, mem[0]},            64'h11223344);
        check_eq("t6_cpu_en", {63'b0, cpu_enable},        64'd1);

`ifdef IMEM_LOADER_READBACK_EN
        // Corrupted readback aborts the session
        base      = lg_addr.size();
        rbase     = ren_cnt;
        force_bad = 1'b1;
        begin_session();
        send_hdr(16'h0001, 0);
        send_word(32'h12345678, 0);
        wait_end();
        force_bad = 1'b0;
        check_eq("t7_error",  {63'b0, error},             64'd1);
        check_eq("t7_cpu_en", {63'b0, cpu_enable},        64'd0);
        check_eq("t7_nwr",    64'(lg_addr.size() - base), 64'd1);
        check_eq("t7_nrd",    64'(ren_cnt - rbase),       64'd1);
`else
        rbase = 0;
        check_eq("no_ren", 64'(ren_cnt), 64'(rbase));
`endif
        check_eq("wen_ren_both", 64'(both_cnt),   64'd0);
        check_eq("ready_in_wr",  64'(rdy_wr_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: MAX_WORDS, 512, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: arst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  in  1  begin a load session (sampled in IDLE/DONE/ERR).
REQ-005 SHALL have port: s_valid  in  1  byte-stream valid.
REQ-006 SHALL have port: s_data  in  8  byte-stream data.
REQ-007 SHALL have port: s_ready  out  1  loader accepts the byte this cycle (transfer = s_valid & s_ready).
REQ-008 SHALL have port: addr_ext  out  64  byte address into instruction memory.
REQ-009 SHALL have port: wen_ext  out  1  instruction-memory write strobe.
REQ-010 SHALL have port: ren_ext  out  1  instruction-memory read strobe.
REQ-011 SHALL have port: wdata_ext  out  32  instruction word to write.
REQ-012 SHALL have port: rdata_ext  in  32  instruction-memory read data, valid the cycle after ren_ext.
REQ-013 SHALL have port: cpu_enable  out  1  run enable to the processor.
REQ-014 SHALL have port: busy  out  1  session in progress.
REQ-015 SHALL have port: error  out  1  session aborted (sticky until next start or reset).

Function
REQ-016 SHALL implement FSM states IDLE, HDR_LO, HDR_HI, DATA, WRITE, RD, CMP, DONE, ERR.
REQ-017 SHALL move IDLE/DONE/ERR -> HDR_LO on start=1; cpu_enable, error cleared on that edge; word index cleared to 0.
REQ-018 SHALL take word count N as a 16-bit little-endian header: HDR_LO accepts the low byte, HDR_HI the high byte.
REQ-019 SHALL, after HDR_HI: N=0 -> DONE; N>MAX_WORDS -> ERR; else -> DATA.
REQ-020 SHALL in DATA assemble 4 accepted bytes little-endian (first byte = wdata_ext[7:0]), then -> WRITE.
REQ-021 SHALL in WRITE assert wen_ext for exactly one cycle with addr_ext = 4*index and the assembled word.
REQ-022 SHALL after WRITE increment index; index==N -> DONE, else -> DATA.
REQ-023 SHALL drive s_ready=1 only in HDR_LO, HDR_HI, DATA; 0 in all other states, including the WRITE cycle.
REQ-024 SHALL tolerate arbitrary s_valid gaps; no byte is lost or duplicated.
REQ-025 SHALL hold cpu_enable=1 only in DONE; busy=1 in every state except IDLE, DONE, ERR.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL keep addr_ext, wdata_ext stable from WRITE/RD until the next index change; wen_ext and ren_ext never both 1.
REQ-028 SHALL minimum throughput: one word per 5 cycles with s_valid held high (4 DATA + 1 WRITE, no readback).

Reset
REQ-029 SHALL on arst=1 immediately enter IDLE and force s_ready, wen_ext, ren_ext, cpu_enable, busy, error to 0 and addr_ext, wdata_ext, index to 0.
REQ-030 SHALL on reset mid-session abandon the partial word; already-written memory words are not restored.

Configuration
REQ-031 SHALL support macro IMEM_LOADER_READBACK_EN.
REQ-032 SHALL with the macro: WRITE -> RD (ren_ext=1 one cycle, same addr) -> CMP (compare rdata_ext to word); mismatch -> ERR, match -> REQ-022 transition.
REQ-033 SHALL without the macro: RD/CMP absent, ren_ext tied 0, rdata_ext unused, WRITE transitions per REQ-022.

Structure
REQ-034 SHALL place the state enum, WORD_BYTES=4, and HDR_BYTES=2 in shared package imem_loader_pkg.
REQ-035 SHALL implement byte assembly in sub-module byte_packer (byte-in, 2-bit count, word-out, full flag).

Verification
REQ-036 SHALL cover: header 0x0002, bytes 13 05 A0 00 93 05 10 00 continuous -> writes 0x00A00513@0, 0x00100593@4; cpu_enable=1 after last write.
REQ-037 SHALL cover: header 0x0000 -> DONE immediately, no wen_ext pulse.
REQ-038 SHALL cover: header 0x0201 (513 > 512) -> ERR, error=1, cpu_enable=0, no write.
REQ-039 SHALL cover: random s_valid gaps on a 16-word image -> memory contents identical to the gap-free run.
REQ-040 SHALL cover: arst pulse after 2 data bytes, then a new 1-word session -> word 0 holds only the new data, partial bytes discarded.
REQ-041 SHALL cover, with IMEM_LOADER_READBACK_EN: rdata_ext forced to 0xDEADBEEF on the first compare -> ERR, error=1, one wen_ext and one ren_ext pulse.
